// File: rtl/masked_bit_feeder.sv
// masked_bit_feeder: stimulus stage for single-bit masked gadgets.
// Takes an unmasked W-bit word and splits each bit into D Boolean shares
// using fresh LFSR randomness. It then streams one shared bit per cycle,
// MSB first.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   in_valid/ready  word handshake; in_data is the unmasked word
//   seed_load/seed  reload the free-running LFSR (a zero seed maps to SEED)
//   out_valid       out_shares carries a valid shared bit (registered)
//   out_shares      D shares; their XOR equals the data bit, zero when idle
//   busy            high while a word is being shifted out
module masked_bit_feeder #(
  parameter int unsigned W    = 8,
  parameter int unsigned D    = 2,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         seed_load,
  input  logic [31:0]  seed,
  output logic         out_valid,
  output logic [D-1:0] out_shares,
  output logic         busy
);

  localparam int unsigned   CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [31:0]   POLY    = 32'h8020_0003;
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SHIFT = 1'b1;

  logic [0:0]   r_state,      w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic [W-1:0] r_shreg,      w_shreg_nxt;
  logic [31:0]  r_lfsr,       w_lfsr_nxt;
  logic         r_out_valid,  w_out_valid_nxt;
  logic [D-1:0] r_out_shares, w_out_shares_nxt;
  logic         w_last;
  logic         w_accept;
  logic         w_bit;
  logic [D-2:0] w_rnd;

  // Ready in IDLE, or on the last bit of a word so the next word follows with no bubble.
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign in_ready = rst && ((r_state == S_IDLE) || w_last);
  assign w_accept = in_valid && in_ready;
  assign w_bit    = r_shreg[W-1];
  assign w_rnd    = r_lfsr[D-2:0];

  assign out_valid  = r_out_valid;
  assign out_shares = r_out_shares;
  assign busy       = (r_state == S_SHIFT);

  // Free-running right-shift Galois LFSR; a seed load takes priority over stepping.
  always_comb begin
    w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'h0);
    if (seed_load) begin
      w_lfsr_nxt = (seed == 32'h0) ? SEED : seed;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_out_valid_nxt  = 1'b0;
    w_out_shares_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = in_data;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The first D-1 shares are raw randomness. The last share folds in the data bit.
        w_out_valid_nxt  = 1'b1;
        w_out_shares_nxt = {w_bit ^ (^w_rnd), w_rnd};
        if (w_last) begin
          w_cnt_nxt = '0;
          if (w_accept) begin
            w_shreg_nxt = in_data;
          end else begin
            w_shreg_nxt = r_shreg << 1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_shreg_nxt = r_shreg << 1;
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_lfsr       <= SEED;
      r_out_valid  <= 1'b0;
      r_out_shares <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_shares <= w_out_shares_nxt;
    end
  end

endmodule

// File: tb/tb_masked_bit_feeder.sv
// Testbench for masked_bit_feeder.
// Checks a D=2 and a D=3 instance against a queue-of-bits reference model
// and a Galois LFSR model. Both instances are driven with identical inputs.
module tb_masked_bit_feeder;

  localparam int unsigned W = 8;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         seed_load;
  logic [31:0]  seed;
  logic         in_ready, out_valid, busy;
  logic [1:0]   out_shares;
  logic         in_ready3, out_valid3, busy3;
  logic [2:0]   out_shares3;

  int n_tests = 0;
  int n_fail  = 0;

  bit          q[$];
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  masked_bit_feeder #(.W(W), .D(2), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_shares(out_shares), .busy(busy));

  masked_bit_feeder #(.W(W), .D(3), .SEED(SEED)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid3), .out_shares(out_shares3), .busy(busy3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // One clock cycle: drive inputs, predict from the model, check the outputs after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic sl, input logic [31:0] sd);
    logic       exp_rdy;
    logic       emit;
    logic       b;
    logic [1:0] exp2;
    logic [2:0] exp3;
    in_valid  = v;
    in_data   = d;
    seed_load = sl;
    seed      = sd;
    #1;
    exp_rdy = (q.size() <= 1);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("in_ready_d3", 64'(in_ready3), 64'(exp_rdy));
    emit = (q.size() > 0);
    b    = 1'b0;
    if (emit) b = q.pop_front();
    if (v && exp_rdy) begin
      for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
    end
    exp2 = emit ? {b ^ m_lfsr[0], m_lfsr[0]} : 2'b00;
    exp3 = emit ? {b ^ m_lfsr[0] ^ m_lfsr[1], m_lfsr[1], m_lfsr[0]} : 3'b000;
    @(posedge clk);
    m_lfsr = sl ? ((sd == 32'h0) ? SEED : sd) : galois(m_lfsr);
    #1;
    chk("out_valid", 64'(out_valid), 64'(emit));
    chk("out_shares", 64'(out_shares), 64'(exp2));
    chk("busy", 64'(busy), 64'(q.size() > 0));
    chk("out_valid_d3", 64'(out_valid3), 64'(emit));
    chk("out_shares_d3", 64'(out_shares3), 64'(exp3));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; seed_load = 1'b0; seed = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_shares", 64'(out_shares), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_lfsr = SEED;

    // A single word.
    step(1'b1, 8'hA5, 1'b0, 32'h0);
    repeat (9) step(1'b0, 8'h00, 1'b0, 32'h0);

    // Back-to-back words: the second is offered on the last bit of the first.
    step(1'b1, 8'hA5, 1'b0, 32'h0);
    repeat (7) step(1'b0, 8'h00, 1'b0, 32'h0);
    step(1'b1, 8'h3C, 1'b0, 32'h0);
    repeat (9) step(1'b0, 8'h00, 1'b0, 32'h0);

    // A zero seed maps to SEED. Then load seed 1 in the middle of a word.
    step(1'b0, 8'h00, 1'b1, 32'h0);
    step(1'b1, 8'hC3, 1'b0, 32'h0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 32'h0);
    step(1'b0, 8'h00, 1'b1, 32'h0000_0001);
    repeat (12) step(1'b0, 8'h00, 1'b0, 32'h0);

    // in_valid held high: only words offered while ready are taken.
    repeat (13) step(1'b1, 8'h00, 1'b0, 32'h0);
    repeat (13) step(1'b1, 8'hFF, 1'b0, 32'h0);
    repeat (9) step(1'b0, 8'h00, 1'b0, 32'h0);

    // An asynchronous reset in the middle of a word aborts it.
    step(1'b1, 8'hFF, 1'b0, 32'h0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 32'h0);
    #3;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_shares", 64'(out_shares), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    q.delete();
    m_lfsr = SEED;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b0, 32'h0);

    // D=3 run.
    step(1'b1, 8'h5A, 1'b0, 32'h0);
    repeat (9) step(1'b0, 8'h00, 1'b0, 32'h0);

    // Randomized traffic with occasional seed loads.
    for (int n = 0; n < 600; n++) begin
      logic        v, sl;
      logic [31:0] sd;
      v  = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(v, W'($urandom), sl, sd);
    end
    repeat (9) step(1'b0, 8'h00, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
